fetch_queue: RTL and testbench

- Instruction-fetch front end directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues in-order requests to instruction memory.
- Buffers returned {PC, instruction} pairs in a small FIFO and presents them to decode as InstrF/PCF/PCPlus4F with a valid flag.
- Drops wrong-path instructions on an EX-stage redirect (PCSrcE/PCTargetE).

---
 rtl/fetch_queue.sv | 126 ++++++++++++
 tb/tb_fetch_queue.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end feeding the IF/ID register.
//   Owns the fetch PC, issues in-order word requests to instruction memory,
//   buffers returned {PC, instruction} pairs in a DEPTH-entry FIFO and presents
//   the head to decode. An EX-stage redirect clears the FIFO, reloads the PC
//   and marks every response still in flight for discard.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   imem_req/addr/gnt          request channel (addr = fetch PC, word aligned)
//   imem_rvalid/rdata          in-order response channel
//   StallD                     decode holds the head entry
//   PCSrcE/PCTargetE           redirect from EX
//   validF/InstrF/PCF/PCPlus4F head entry to decode (zero when not valid)
//   perf_stall_cnt/flush_cnt   performance counters
// Optional feature: define FETCH_QUEUE_PERF_EN to build the performance
// counters; otherwise both counter ports read 32'h0.
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4,
    parameter int          CW       = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        StallD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        validF,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   fetch_pc;
    logic [CW-1:0] count, outstanding, drop_cnt;
    logic [AW-1:0] rd_ptr, wr_ptr;     // instruction FIFO
    logic [AW-1:0] pq_rd, pq_wr;       // PCs of granted, unanswered requests
    logic [31:0]   fifo_instr [DEPTH];
    logic [31:0]   fifo_pc    [DEPTH];
    logic [31:0]   pc_queue   [DEPTH];

    logic [CW:0] occupancy;
    logic        grant, push, pop;

    // count + outstanding never exceeds DEPTH, the extra bit only keeps the
    // sum from wrapping in the compare.
    assign occupancy = {1'b0, count} + {1'b0, outstanding};
    assign imem_req  = (occupancy < (CW+1)'(DEPTH)) && !PCSrcE;
    assign imem_addr = fetch_pc;
    assign grant     = imem_req && imem_gnt;
    assign push      = imem_rvalid && (drop_cnt == '0) && !PCSrcE;
    assign pop       = validF && !StallD;

    assign validF   = (count != '0);
    assign InstrF   = validF ? fifo_instr[rd_ptr]      : 32'h0;
    assign PCF      = validF ? fifo_pc[rd_ptr]         : 32'h0;
    assign PCPlus4F = validF ? fifo_pc[rd_ptr] + 32'd4 : 32'h0;

    // Storage arrays carry no reset; the pointers/counters qualify them.
    always_ff @(posedge clk) begin
        if (grant) pc_queue[pq_wr] <= fetch_pc;
        if (push) begin
            fifo_instr[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]    <= pc_queue[pq_rd];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            pq_rd       <= '0;
            pq_wr       <= '0;
        end else begin
            // The PC queue tracks the memory pipeline and is never flushed:
            // wrong-path responses still arrive and must pop it.
            outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid);
            if (grant)       pq_wr <= pq_wr + 1'b1;
            if (imem_rvalid) pq_rd <= pq_rd + 1'b1;

            if (PCSrcE) begin
                fetch_pc <= PCTargetE & ~32'h3;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                // Everything still in flight after this cycle is wrong-path.
                // drop_cnt is already a subset of outstanding, so the new
                // value is the post-cycle outstanding count (no grant can
                // coincide with a redirect).
                drop_cnt <= outstanding - CW'(imem_rvalid);
            end else begin
                if (grant) fetch_pc <= fetch_pc + 32'd4;
                if (imem_rvalid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cnt <= 32'h0;
            perf_flush_cnt <= 32'h0;
        end else begin
            if (validF && StallD) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (PCSrcE)           perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`else
    assign perf_stall_cnt = 32'h0;
    assign perf_flush_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue. A queue-based reference model (fetch PC,
// list of in-flight PCs, number to discard, FIFO of {pc,instr}) plus an
// in-order memory model with configurable latency is stepped once per cycle.
module tb_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk, reset;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        StallD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        validF;
    logic [31:0] InstrF, PCF, PCPlus4F, perf_stall_cnt, perf_flush_cnt;

    fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .StallD(StallD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .validF(validF), .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } mreq_t;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int lat   = 1;

    mreq_t       mem_q[$];
    logic [31:0] inflight[$];
    logic [31:0] q_pc[$];
    logic [31:0] q_ins[$];
    int          m_drop;
    logic [31:0] m_pc, m_stall, m_flush;

    function automatic logic [31:0] ifun(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] exp_perf(input logic [31:0] v);
`ifdef FETCH_QUEUE_PERF_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    task automatic model_clear;
        mem_q.delete(); inflight.delete(); q_pc.delete(); q_ins.delete();
        m_drop = 0; m_pc = RESET_PC; m_stall = 0; m_flush = 0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        PCSrcE = 1'b0; StallD = 1'b0; PCTargetE = 32'h0;
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // One clock cycle: drive inputs at the falling edge, compare the cycle's
    // outputs with the model, then advance the model as the rising edge will.
    task automatic step(input logic stall, input logic redir,
                        input logic [31:0] tgt, input logic gnt);
        logic        rv, exp_req, exp_v;
        logic [31:0] rd, rpc;
        @(negedge clk);
        rv = 1'b0; rd = 32'h0;
        if (mem_q.size() > 0) if (mem_q[0].due <= cyc) begin
            rv = 1'b1; rd = ifun(mem_q[0].addr);
        end
        imem_rvalid = rv; imem_rdata = rd; imem_gnt = gnt;
        StallD = stall; PCSrcE = redir; PCTargetE = tgt;
        #1;
        exp_req = (q_pc.size() + inflight.size() < DEPTH) && !redir;
        exp_v   = q_pc.size() != 0;
        tests++;
        if (imem_req !== exp_req || imem_addr !== m_pc) begin
            fails++;
            $display("FAIL req c%0d: got req=%b addr=%h exp req=%b addr=%h",
                     cyc, imem_req, imem_addr, exp_req, m_pc);
        end
        tests++;
        if (exp_v) begin
            if (validF !== 1'b1 || PCF !== q_pc[0] || InstrF !== q_ins[0] ||
                PCPlus4F !== q_pc[0] + 32'd4) begin
                fails++;
                $display("FAIL head c%0d: got v=%b pc=%h ins=%h p4=%h exp pc=%h ins=%h",
                         cyc, validF, PCF, InstrF, PCPlus4F, q_pc[0], q_ins[0]);
            end
        end else if (validF !== 1'b0 || PCF !== 32'h0 || InstrF !== 32'h0 ||
                     PCPlus4F !== 32'h0) begin
            fails++;
            $display("FAIL empty c%0d: got v=%b pc=%h ins=%h p4=%h exp all zero",
                     cyc, validF, PCF, InstrF, PCPlus4F);
        end
        tests++;
        if (perf_stall_cnt !== exp_perf(m_stall) || perf_flush_cnt !== exp_perf(m_flush)) begin
            fails++;
            $display("FAIL perf c%0d: got stall=%0d flush=%0d exp stall=%0d flush=%0d",
                     cyc, perf_stall_cnt, perf_flush_cnt, exp_perf(m_stall), exp_perf(m_flush));
        end
        // model advance
        if (exp_v && stall) m_stall++;
        if (redir) m_flush++;
        rpc = 32'h0;
        if (rv) begin
            void'(mem_q.pop_front());
            rpc = inflight.pop_front();
        end
        if (exp_req && gnt) begin
            inflight.push_back(m_pc);
            mem_q.push_back('{addr: m_pc, due: cyc + lat});
            m_pc = m_pc + 32'd4;
        end
        if (redir) begin
            q_pc.delete(); q_ins.delete();
            m_drop = inflight.size();
            m_pc   = tgt & ~32'h3;
        end else begin
            if (exp_v && !stall) begin
                void'(q_pc.pop_front()); void'(q_ins.pop_front());
            end
            if (rv) begin
                if (m_drop > 0) m_drop--;
                else begin q_pc.push_back(rpc); q_ins.push_back(rd); end
            end
        end
        cyc++;
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        PCSrcE = 1'b0; StallD = 1'b1; PCTargetE = 32'h0;
        model_clear();
        #1;
        tests++;
        if (validF !== 1'b0 || PCF !== 32'h0 || InstrF !== 32'h0 || PCPlus4F !== 32'h0 ||
            imem_addr !== RESET_PC || imem_req !== 1'b1 ||
            perf_stall_cnt !== 32'h0 || perf_flush_cnt !== 32'h0) begin
            fails++;
            $display("FAIL reset_state: got v=%b pc=%h ins=%h addr=%h req=%b exp v=0 addr=%h req=1",
                     validF, PCF, InstrF, imem_addr, imem_req, RESET_PC);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic;
        logic [31:0] exp_a [3];
        exp_a[0] = 32'h0; exp_a[1] = 32'h4; exp_a[2] = 32'h8;
        do_reset(); lat = 1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            tests++;
            if (imem_req !== 1'b1 || imem_addr !== exp_a[i]) begin
                fails++;
                $display("FAIL basic_addr%0d: got %h exp %h", i, imem_addr, exp_a[i]);
            end
        end
        tests++;
        if (validF !== 1'b1 || PCF !== 32'h0 || PCPlus4F !== 32'h4 || InstrF !== ifun(32'h0)) begin
            fails++;
            $display("FAIL basic_first: got v=%b pc=%h p4=%h ins=%h exp v=1 pc=0 p4=4 ins=%h",
                     validF, PCF, PCPlus4F, InstrF, ifun(32'h0));
        end
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_stall;
        logic [31:0] seen[$];
        do_reset(); lat = 1;
        repeat (2) step(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            tests++;
            if (PCF !== 32'h0) begin
                fails++; $display("FAIL stall_hold%0d: got %h exp 00000000", i, PCF);
            end
        end
        tests++;
        if (imem_req !== 1'b0 || validF !== 1'b1) begin
            fails++; $display("FAIL stall_full: got req=%b v=%b exp req=0 v=1", imem_req, validF);
        end
        for (int i = 0; i < 10 && seen.size() < 4; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (i == 0) begin
                tests++;
                if (perf_stall_cnt !== exp_perf(32'd10)) begin
                    fails++; $display("FAIL stall_perf: got %0d exp %0d", perf_stall_cnt, exp_perf(32'd10));
                end
            end
            if (validF) seen.push_back(PCF);
        end
        tests++;
        if (seen.size() != 4 || seen[0] !== 32'h0 || seen[1] !== 32'h4 ||
            seen[2] !== 32'h8 || seen[3] !== 32'hC) begin
            fails++; $display("FAIL stall_order: got %0d entries, exp 0,4,8,C", seen.size());
        end
    endtask

    task automatic test_redirect_inflight;
        bit found;
        do_reset(); lat = 3;
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h100, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        tests++;
        if (validF !== 1'b0 || imem_addr !== 32'h100) begin
            fails++; $display("FAIL redir_flush: got v=%b addr=%h exp v=0 addr=00000100", validF, imem_addr);
        end
        tests++;
        if (perf_flush_cnt !== exp_perf(32'd1)) begin
            fails++; $display("FAIL redir_perf: got %0d exp %0d", perf_flush_cnt, exp_perf(32'd1));
        end
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (validF) found = 1;
        end
        tests++;
        if (!found || PCF !== 32'h100) begin
            fails++; $display("FAIL redir_first: got found=%0d pc=%h exp pc=00000100", found, PCF);
        end
    endtask

    task automatic test_redirect_rvalid;
        do_reset(); lat = 1;
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h202, 1'b1);
        tests++;
        if (imem_req !== 1'b0 || imem_rvalid !== 1'b1) begin
            fails++; $display("FAIL redir_rv_req: got req=%b rv=%b exp req=0 rv=1", imem_req, imem_rvalid);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        tests++;
        if (imem_addr !== 32'h200 || validF !== 1'b0) begin
            fails++; $display("FAIL redir_rv_addr: got addr=%h v=%b exp addr=00000200 v=0", imem_addr, validF);
        end
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_gnt_low;
        do_reset(); lat = 2;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            tests++;
            if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
                fails++; $display("FAIL gnt_hold%0d: got req=%b addr=%h exp req=1 addr=%h",
                                  i, imem_req, imem_addr, RESET_PC);
            end
        end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        tests++;
        if (imem_addr !== RESET_PC + 32'd4) begin
            fails++; $display("FAIL gnt_adv: got %h exp %h", imem_addr, RESET_PC + 32'd4);
        end
    endtask

    task automatic test_wrap;
        bit found;
        do_reset(); lat = 1;
        step(1'b0, 1'b1, 32'hFFFF_FFF9, 1'b1);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (validF && PCF === 32'hFFFF_FFFC) found = 1;
        end
        tests++;
        if (!found || PCPlus4F !== 32'h0) begin
            fails++; $display("FAIL wrap_p4: got found=%0d p4=%h exp 00000000", found, PCPlus4F);
        end
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_reset_mid;
        do_reset(); lat = 1;
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);
        #6;
        tests++;
        if (validF !== 1'b1) begin
            fails++; $display("FAIL rstmid_pre: got v=%b exp 1", validF);
        end
        reset = 1'b0;
        #1;
        tests++;
        if (validF !== 1'b0 || PCF !== 32'h0 || imem_addr !== RESET_PC) begin
            fails++; $display("FAIL rstmid_async: got v=%b pc=%h addr=%h exp v=0 pc=0 addr=%h",
                              validF, PCF, imem_addr, RESET_PC);
        end
        imem_gnt = 1'b0; imem_rvalid = 1'b0; PCSrcE = 1'b0; StallD = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        step(1'b0, 1'b0, 32'h0, 1'b1);
        tests++;
        if (imem_addr !== RESET_PC || imem_req !== 1'b1) begin
            fails++; $display("FAIL rstmid_addr: got addr=%h req=%b exp addr=%h req=1",
                              imem_addr, imem_req, RESET_PC);
        end
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_random;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            lat = int'($urandom_range(1, 4));
            step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 6,
                 $urandom, $urandom_range(0, 99) < 75);
        end
    endtask

    initial begin
        reset = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        StallD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
        model_clear();
        test_reset();
        test_basic();
        test_stall();
        test_redirect_inflight();
        test_redirect_rvalid();
        test_gnt_low();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
